// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for the shared 8x8 multiply / 16-bit accumulate datapath.
// Takes a length and a start pulse, clears the MAC, streams operand pairs into it
// over valid/ready, then captures the final accumulator on a valid/ready result port.
// Optional feature macro: MAC_SEQ_OVF_EN (sticky 16-bit accumulate overflow flag on res_ovf).
module mac_seq_ctrl #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [15:0]      mac_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      res_q, res_d;
  logic             hs;

  // Handshake and datapath drive are pure functions of state and inputs
  assign in_ready  = (state_q == S_RUN);
  assign hs        = in_valid & in_ready;
  assign mac_en    = hs;
  assign mac_a     = hs ? in_a : '0;
  assign mac_b     = hs ? in_b : '0;
  assign mac_clr   = (state_q == S_CLEAR);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_q;

  // State, element counter and captured result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Next-state, counter and result capture
  // len is loaded into the counter on the start edge rather than in CLEAR, so a
  // len change during CLEAR cannot leak in; the counter is not observable in between.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            cnt_d   = len;
            state_d = S_CLEAR;
          end else begin
            res_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (hs) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        res_d   = mac_acc;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef MAC_SEQ_OVF_EN
  logic        ovf_q, ovf_d;
  logic [15:0] prod;
  logic        carry;

  assign prod  = in_a * in_b;
  // Carry out of {1'b0,mac_acc} + prod, written as prod > (16'hFFFF - mac_acc)
  assign carry = (prod > ~mac_acc);

  // Sticky overflow: cleared when a new vector starts, set on any carrying handshake
  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == S_IDLE) && start && (len == '0)) begin
      ovf_d = 1'b0;
    end else if (state_q == S_CLEAR) begin
      ovf_d = 1'b0;
    end else if (hs && carry) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign res_ovf = ovf_q;
`else
  assign res_ovf = 1'b0;
`endif

endmodule
